// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate L1 data cache.
// Each line holds one 32-bit word. The cache sits between the MEM stage and
// the data memory / MMIO bus. Accesses to the MMIO region bypass the cache.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   cpu_req         MEM-stage access valid (held stable while dcache_stall=1)
//   cpu_we          1 = store, 0 = load
//   cpu_addr        byte address; bits [1:0] are ignored
//   cpu_wdata       store data
//   cpu_wmask       store byte enables
//   cpu_rdata       load data, valid when cpu_req & !cpu_we & !dcache_stall
//   dcache_stall    freeze the pipeline this cycle
//   mem_req         bus request, held until mem_ack
//   mem_we          bus write
//   mem_addr        word-aligned bus address
//   mem_wdata       bus write data
//   mem_wmask       bus byte enables
//   mem_ack         one-cycle completion pulse; mem_rdata is valid with it
//   mem_rdata       bus read data
//   perf_hit        saturating count of cached load hits
//   perf_miss       saturating count of cached load misses
module dcache_ctrl #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          INDEX_W  = 6,
  parameter logic [3:0]  MMIO_TAG = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_wmask,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dcache_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    BYPASS_RD,
    RESP
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  // Storage: data and tags are never reset; valid bits gate every use of them.
  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic              unc_q;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       perf_hit_q;
  logic [31:0]       perf_miss_q;

  // Lookup of the incoming request (used in IDLE)
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req_unc;
  logic               req_hit;
  logic               load_hit;
  logic               need_bus;

  // Lookup of the latched request (used when a store completes)
  logic [INDEX_W-1:0] lat_idx;
  logic [TAG_W-1:0]   lat_tag;
  logic               lat_hit;

  assign req_idx  = cpu_addr[INDEX_W+1:2];
  assign req_tag  = cpu_addr[ADDR_W-1:INDEX_W+2];
  assign req_unc  = (cpu_addr[ADDR_W-1:ADDR_W-4] == MMIO_TAG);
  assign req_hit  = !req_unc && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign load_hit = (state_q == IDLE) && cpu_req && !cpu_we && req_hit;
  assign need_bus = cpu_req && (cpu_we || !req_hit);

  assign lat_idx = addr_q[INDEX_W+1:2];
  assign lat_tag = addr_q[ADDR_W-1:INDEX_W+2];
  assign lat_hit = !unc_q && valid_q[lat_idx] && (tag_mem[lat_idx] == lat_tag);

  // Hits return straight from the array; everything else returns the captured word.
  assign cpu_rdata = load_hit ? data_mem[req_idx] : rdata_q;

  always_comb begin
    dcache_stall = 1'b0;
    case (state_q)
      IDLE:                       dcache_stall = need_bus;
      RD_MISS, WR_THRU, BYPASS_RD: dcache_stall = cpu_req;
      default:                    dcache_stall = 1'b0;
    endcase
  end

  // Bus side is decoded from the state register and the latched request only.
  assign mem_req   = (state_q == RD_MISS) || (state_q == WR_THRU) || (state_q == BYPASS_RD);
  assign mem_we    = (state_q == WR_THRU);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = (state_q == WR_THRU) ? wmask_q : 4'b0000;

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      unc_q       <= 1'b0;
      rdata_q     <= '0;
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (need_bus) begin
              addr_q  <= cpu_addr & ~ADDR_W'(3);
              wdata_q <= cpu_wdata;
              wmask_q <= cpu_wmask;
              unc_q   <= req_unc;
            end
            if (cpu_we) begin
              state_q <= WR_THRU;
            end else if (req_unc) begin
              state_q <= BYPASS_RD;
            end else if (req_hit) begin
              perf_hit_q <= sat_inc(perf_hit_q);
            end else begin
              perf_miss_q <= sat_inc(perf_miss_q);
              state_q     <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            data_mem[lat_idx] <= mem_rdata;
            tag_mem[lat_idx]  <= lat_tag;
            valid_q[lat_idx]  <= 1'b1;
            rdata_q           <= mem_rdata;
            state_q           <= RESP;
          end
        end
        BYPASS_RD: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state_q <= RESP;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            // Write-through: only an already-present line is updated, never allocated.
            if (lat_hit) data_mem[lat_idx] <= merge_bytes(data_mem[lat_idx], wdata_q, wmask_q);
            state_q <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        dcache_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] perf_hit, perf_miss;

  int tests = 0;
  int fails = 0;

  // Results of the most recent access
  int          a_stalls;
  int          a_reqs;
  logic [31:0] a_rdata;
  logic        a_saw_we;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wmask;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata),
    .dcache_stall(dcache_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  // Entered and left at posedge+1. Acks in the ack_delay-th cycle of mem_req.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int ack_delay, input logic [31:0] ack_data);
    logic done;
    done = 1'b0;
    a_stalls = 0; a_reqs = 0; a_saw_we = 1'b0;
    a_addr = '0; a_wdata = '0; a_wmask = '0; a_rdata = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = wmask;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (!dcache_stall) begin
        a_rdata = cpu_rdata;
        done = 1'b1;
        break;
      end
      a_stalls++;
      if (mem_req) begin
        a_reqs++;
        if (mem_we) a_saw_we = 1'b1;
        a_addr = mem_addr; a_wdata = mem_wdata; a_wmask = mem_wmask;
        if (a_reqs == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = ack_data;
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL access_timeout addr=%h: stall still %b, required 0 within 40 cycles", addr, dcache_stall);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (dcache_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", dcache_stall); end
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rst_memreq got req=%b we=%b want 0/0", mem_req, mem_we); end
    tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
      fails++; $display("FAIL rst_membus got %h %h %h want 0 0 0", mem_addr, mem_wdata, mem_wmask); end
    tests++; if (cpu_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", cpu_rdata); end
    tests++; if (perf_hit !== 32'h0 || perf_miss !== 32'h0) begin fails++; $display("FAIL rst_perf got %0d/%0d want 0/0", perf_hit, perf_miss); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_miss_hit();
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'hDEAD_BEEF);
    tests++; if (a_stalls != 2) begin fails++; $display("FAIL miss_stall got %0d want 2", a_stalls); end
    tests++; if (a_addr !== 32'h0000_0100 || a_saw_we !== 1'b0) begin fails++; $display("FAIL miss_bus got addr=%h we=%b want 00000100/0", a_addr, a_saw_we); end
    tests++; if (a_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL miss_rdata got %h want deadbeef", a_rdata); end
    tests++; if (perf_miss !== 32'd1) begin fails++; $display("FAIL miss_count got %0d want 1", perf_miss); end
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0BAD_0BAD);
    tests++; if (a_stalls != 0 || a_reqs != 0) begin fails++; $display("FAIL hit_stall got %0d/%0d want 0/0", a_stalls, a_reqs); end
    tests++; if (a_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hit_rdata got %h want deadbeef", a_rdata); end
    tests++; if (perf_hit !== 32'd1) begin fails++; $display("FAIL hit_count got %0d want 1", perf_hit); end
  endtask

  task automatic test_store_hit();
    access(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 3, 32'h0);
    tests++; if (a_stalls != 4) begin fails++; $display("FAIL st_stall got %0d want 4", a_stalls); end
    tests++; if (a_saw_we !== 1'b1 || a_wdata !== 32'h1234_5678 || a_wmask !== 4'b0011) begin
      fails++; $display("FAIL st_bus got we=%b d=%h m=%b want 1/12345678/0011", a_saw_we, a_wdata, a_wmask); end
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0);
    tests++; if (a_stalls != 0 || a_rdata !== 32'hDEAD_5678) begin
      fails++; $display("FAIL st_merge got stall=%0d rdata=%h want 0/dead5678", a_stalls, a_rdata); end
    tests++; if (perf_hit !== 32'd2 || perf_miss !== 32'd1) begin fails++; $display("FAIL st_counts got %0d/%0d want 2/1", perf_hit, perf_miss); end
  endtask

  task automatic test_store_no_alloc();
    access(1'b1, 32'h0000_0200, 32'hAAAA_5555, 4'b1111, 1, 32'h0);
    tests++; if (a_stalls != 2) begin fails++; $display("FAIL na_st_stall got %0d want 2", a_stalls); end
    access(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 32'hCAFE_F00D);
    tests++; if (a_stalls != 2 || a_rdata !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL na_load got stall=%0d rdata=%h want 2/cafef00d", a_stalls, a_rdata); end
    tests++; if (perf_miss !== 32'd2) begin fails++; $display("FAIL na_count got %0d want 2", perf_miss); end
  endtask

  task automatic test_conflict();
    do_reset();
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0000_00A1);
    access(1'b0, 32'h0000_1100, 32'h0, 4'h0, 2, 32'h0000_00B2);
    tests++; if (a_stalls != 3 || a_rdata !== 32'h0000_00B2) begin
      fails++; $display("FAIL cf_second got stall=%0d rdata=%h want 3/000000b2", a_stalls, a_rdata); end
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0000_00C3);
    tests++; if (a_stalls != 2 || a_rdata !== 32'h0000_00C3) begin
      fails++; $display("FAIL cf_third got stall=%0d rdata=%h want 2/000000c3", a_stalls, a_rdata); end
    tests++; if (perf_miss !== 32'd3 || perf_hit !== 32'd0) begin fails++; $display("FAIL cf_counts got %0d/%0d want 0/3", perf_hit, perf_miss); end
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h0);
    tests++; if (a_stalls != 0 || a_rdata !== 32'h0000_00C3 || perf_hit !== 32'd1) begin
      fails++; $display("FAIL cf_rehit got stall=%0d rdata=%h hit=%0d want 0/000000c3/1", a_stalls, a_rdata, perf_hit); end
  endtask

  task automatic test_mmio();
    access(1'b0, 32'hF000_0004, 32'h0, 4'h0, 1, 32'h1111_2222);
    tests++; if (a_stalls != 2 || a_addr !== 32'hF000_0004 || a_rdata !== 32'h1111_2222) begin
      fails++; $display("FAIL mmio_first got stall=%0d addr=%h rdata=%h want 2/f0000004/11112222", a_stalls, a_addr, a_rdata); end
    access(1'b0, 32'hF000_0004, 32'h0, 4'h0, 2, 32'h3333_4444);
    tests++; if (a_stalls != 3 || a_reqs != 2 || a_rdata !== 32'h3333_4444) begin
      fails++; $display("FAIL mmio_second got stall=%0d reqs=%0d rdata=%h want 3/2/33334444", a_stalls, a_reqs, a_rdata); end
    tests++; if (perf_hit !== 32'd1 || perf_miss !== 32'd3) begin fails++; $display("FAIL mmio_counts got %0d/%0d want 1/3", perf_hit, perf_miss); end
  endtask

  task automatic test_back_to_back();
    // Refill at index 1 immediately followed by a hit to the same line.
    access(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1, 32'h5A5A_0001);
    access(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1, 32'h0);
    tests++; if (a_stalls != 0 || a_rdata !== 32'h5A5A_0001) begin
      fails++; $display("FAIL b2b_hit got stall=%0d rdata=%h want 0/5a5a0001", a_stalls, a_rdata); end
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104; cpu_wdata = '0; cpu_wmask = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (mem_req !== 1'b1 || dcache_stall !== 1'b1) begin
      fails++; $display("FAIL rm_busy got req=%b stall=%b want 1/1", mem_req, dcache_stall); end
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (mem_req !== 1'b0 || dcache_stall !== 1'b0) begin
      fails++; $display("FAIL rm_after got req=%b stall=%b want 0/0", mem_req, dcache_stall); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    tests++; if (mem_req !== 1'b0 || perf_miss !== 32'd0 || perf_hit !== 32'd0) begin
      fails++; $display("FAIL rm_lateack got req=%b miss=%0d hit=%0d want 0/0/0", mem_req, perf_miss, perf_hit); end
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'h7777_7777);
    tests++; if (a_stalls != 2 || a_rdata !== 32'h7777_7777) begin
      fails++; $display("FAIL rm_reload got stall=%0d rdata=%h want 2/77777777", a_stalls, a_rdata); end
    access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h8888_8888);
    tests++; if (a_stalls != 2 || perf_miss !== 32'd2) begin
      fails++; $display("FAIL rm_prior_line got stall=%0d miss=%0d want 2/2", a_stalls, perf_miss); end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wmask = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_miss_hit();
    test_store_hit();
    test_store_no_alloc();
    test_conflict();
    test_mmio();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
